// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared sizing constants and writeback request types for the register-file
// writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int unsigned RegisterSize   = 8;
  localparam int unsigned VecSize        = 16;
  localparam int unsigned ScalarQuantity = 16;
  localparam int unsigned VectorQuantity = 4;
  localparam int unsigned SelectionBits  = 4;
  localparam int unsigned DataWidth      = RegisterSize * VecSize;
  localparam int unsigned VecIdxBits     = $clog2(VectorQuantity);

  typedef logic [DataWidth-1:0] vec_data_t;

  typedef struct packed {
    logic [SelectionBits-1:0] rnum;
    logic                     is_vec;
    vec_data_t                data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: the requester that was not granted last wins
// a tie; the pointer moves only when a grant is issued.
module regfile_wb_scheduler_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       gnt_idx
);

  logic last_q;

  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | last_q);
    grant[1] = valid[1] & (~valid[0] | ~last_q);
  end

  assign gnt_idx = grant[1];

  // Reset value 1 makes source 0 the winner of the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owns the register-file write port: arbitrates ALU/MEM writeback, registers
// the write stage, and keeps the scalar/vector busy scoreboard for decode.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               wbValid,
  output logic [1:0]               wbReady,
  input  logic [SelectionBits-1:0] wbReg0,
  input  logic [SelectionBits-1:0] wbReg1,
  input  logic [1:0]               wbIsVec,
  input  logic [DataWidth-1:0]     wbData0,
  input  logic [DataWidth-1:0]     wbData1,
  input  logic                     resvEn,
  input  logic [SelectionBits-1:0] resvReg,
  input  logic                     resvIsVec,
  input  logic [SelectionBits-1:0] qSel1,
  input  logic [SelectionBits-1:0] qSel2,
  input  logic                     qIsVec1,
  input  logic                     qIsVec2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     resvErr,
  output logic                     regWrEnSc,
  output logic                     regWrEnVec,
  output logic [SelectionBits-1:0] regToWrite,
  output logic [DataWidth-1:0]     dataIn
);

  logic [1:0] valid_gated;
  logic [1:0] grant;
  logic       gnt_idx;
  logic       transfer;
  wb_req_t    sel_req;

  // Holding reset low must also force wbReady to 0, so no transfer occurs.
  assign valid_gated = wbValid & {2{reset}};

  regfile_wb_scheduler_rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid_gated),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  assign wbReady  = grant;
  assign transfer = |grant;

  always_comb begin
    if (gnt_idx) begin
      sel_req = '{rnum: wbReg1, is_vec: wbIsVec[1], data: wbData1};
    end else begin
      sel_req = '{rnum: wbReg0, is_vec: wbIsVec[0], data: wbData0};
    end
  end

  logic                     en_sc_q, en_vec_q;
  logic [SelectionBits-1:0] addr_q;
  vec_data_t                data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sc_q  <= 1'b0;
      en_vec_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      en_sc_q  <= transfer & ~sel_req.is_vec;
      en_vec_q <= transfer & sel_req.is_vec;
      if (transfer) begin
        addr_q <= sel_req.rnum;
        data_q <= sel_req.data;
      end
    end
  end

  assign regWrEnSc  = en_sc_q;
  assign regWrEnVec = en_vec_q;
  assign regToWrite = addr_q;
  assign dataIn     = data_q;

  logic [ScalarQuantity-1:0] busy_sc_q, busy_sc_d, clr_sc;
  logic [VectorQuantity-1:0] busy_vec_q, busy_vec_d, clr_vec;
  logic [VecIdxBits-1:0]     wr_vidx, resv_vidx;
  logic                      resv_conflict;
  logic                      resv_err_q;

  assign wr_vidx   = addr_q[VecIdxBits-1:0];
  assign resv_vidx = resvReg[VecIdxBits-1:0];

  // Clear is applied before set so a same-edge reservation survives and a
  // bit being retired this edge does not count as a WAW conflict.
  always_comb begin
    clr_sc  = '0;
    clr_vec = '0;
    if (en_sc_q)  clr_sc[addr_q]   = 1'b1;
    if (en_vec_q) clr_vec[wr_vidx] = 1'b1;
    busy_sc_d     = busy_sc_q & ~clr_sc;
    busy_vec_d    = busy_vec_q & ~clr_vec;
    resv_conflict = 1'b0;
    if (resvEn) begin
      if (resvIsVec) begin
        resv_conflict         = busy_vec_d[resv_vidx];
        busy_vec_d[resv_vidx] = 1'b1;
      end else begin
        resv_conflict       = busy_sc_d[resvReg];
        busy_sc_d[resvReg]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_sc_q  <= '0;
      busy_vec_q <= '0;
      resv_err_q <= 1'b0;
    end else begin
      busy_sc_q  <= busy_sc_d;
      busy_vec_q <= busy_vec_d;
      resv_err_q <= resv_err_q | resv_conflict;
    end
  end

  assign resvErr = resv_err_q;
  assign hazard1 = qIsVec1 ? busy_vec_q[qSel1[VecIdxBits-1:0]] : busy_sc_q[qSel1];
  assign hazard2 = qIsVec2 ? busy_vec_q[qSel2[VecIdxBits-1:0]] : busy_sc_q[qSel2];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: a cycle-by-cycle vector table plus
// hand-written sequences for reservation conflicts and asynchronous reset.
module tb_regfile_wb_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   wbValid, wbReady, wbIsVec;
  logic [3:0]   wbReg0, wbReg1, resvReg, qSel1, qSel2, regToWrite;
  logic [127:0] wbData0, wbData1, dataIn;
  logic         resvEn, resvIsVec, qIsVec1, qIsVec2;
  logic         hazard1, hazard2, resvErr, regWrEnSc, regWrEnVec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .wbValid    (wbValid),
    .wbReady    (wbReady),
    .wbReg0     (wbReg0),
    .wbReg1     (wbReg1),
    .wbIsVec    (wbIsVec),
    .wbData0    (wbData0),
    .wbData1    (wbData1),
    .resvEn     (resvEn),
    .resvReg    (resvReg),
    .resvIsVec  (resvIsVec),
    .qSel1      (qSel1),
    .qSel2      (qSel2),
    .qIsVec1    (qIsVec1),
    .qIsVec2    (qIsVec2),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .resvErr    (resvErr),
    .regWrEnSc  (regWrEnSc),
    .regWrEnVec (regWrEnVec),
    .regToWrite (regToWrite),
    .dataIn     (dataIn)
  );

  typedef struct {
    logic [1:0] v;
    logic [1:0] vec;
    logic [3:0] r0;
    logic [3:0] r1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       re;
    logic [3:0] rr;
    logic       rv;
    logic [3:0] q1;
    logic       qv1;
    logic [3:0] q2;
    logic       qv2;
    logic [1:0] rdy;
    logic       esc;
    logic       evec;
    logic [3:0] addr;
    logic [7:0] dat;
    logic       h1;
    logic       h2;
    logic       err;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wbValid = 2'b00; wbIsVec = 2'b00; wbReg0 = 4'd0; wbReg1 = 4'd0;
    wbData0 = '0; wbData1 = '0;
    resvEn = 1'b0; resvReg = 4'd0; resvIsVec = 1'b0;
    qSel1 = 4'd0; qIsVec1 = 1'b0; qSel2 = 4'd0; qIsVec2 = 1'b0;
  endtask

  task automatic apply(input vec_t t);
    wbValid = t.v; wbIsVec = t.vec; wbReg0 = t.r0; wbReg1 = t.r1;
    wbData0 = {16{t.d0}}; wbData1 = {16{t.d1}};
    resvEn = t.re; resvReg = t.rr; resvIsVec = t.rv;
    qSel1 = t.q1; qIsVec1 = t.qv1; qSel2 = t.q2; qIsVec2 = t.qv2;
  endtask

  initial begin
    // v vec r0 r1 d0 d1 | re rr rv | q1 qv1 q2 qv2 || rdy esc evec addr dat h1 h2 err
    tbl[0]  = '{2'd0, 2'd0, 4'd0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0,
                2'd0, 0, 0, 4'd0, 8'h00, 0, 0, 0};
    tbl[1]  = '{2'd1, 2'd0, 4'd5, 4'd0, 8'hA5, 8'h00, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0,
                2'd1, 0, 0, 4'd0, 8'h00, 0, 0, 0};
    tbl[2]  = '{2'd0, 2'd0, 4'd0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0,
                2'd0, 1, 0, 4'd5, 8'hA5, 0, 0, 0};
    tbl[3]  = '{2'd3, 2'd2, 4'd1, 4'd2, 8'h11, 8'h22, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0,
                2'd2, 0, 0, 4'd5, 8'hA5, 0, 0, 0};
    tbl[4]  = '{2'd3, 2'd2, 4'd1, 4'd2, 8'h11, 8'h22, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0,
                2'd1, 0, 1, 4'd2, 8'h22, 0, 0, 0};
    tbl[5]  = '{2'd3, 2'd2, 4'd1, 4'd2, 8'h11, 8'h22, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0,
                2'd2, 1, 0, 4'd1, 8'h11, 0, 0, 0};
    tbl[6]  = '{2'd3, 2'd2, 4'd1, 4'd2, 8'h11, 8'h22, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0,
                2'd1, 0, 1, 4'd2, 8'h22, 0, 0, 0};
    tbl[7]  = '{2'd0, 2'd0, 4'd0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0,
                2'd0, 1, 0, 4'd1, 8'h11, 0, 0, 0};
    tbl[8]  = '{2'd0, 2'd0, 4'd0, 4'd0, 8'h00, 8'h00, 1, 4'd3, 1, 4'd3, 1, 4'd0, 0,
                2'd0, 0, 0, 4'd1, 8'h11, 0, 0, 0};
    tbl[9]  = '{2'd2, 2'd2, 4'd0, 4'd3, 8'h00, 8'h33, 0, 4'd0, 0, 4'd3, 1, 4'd7, 1,
                2'd2, 0, 0, 4'd1, 8'h11, 1, 1, 0};
    tbl[10] = '{2'd0, 2'd0, 4'd0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 4'd3, 1, 4'd3, 0,
                2'd0, 0, 1, 4'd3, 8'h33, 1, 0, 0};
    tbl[11] = '{2'd0, 2'd0, 4'd0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 4'd3, 1, 4'd3, 0,
                2'd0, 0, 0, 4'd3, 8'h33, 0, 0, 0};

    // Reset asserted from time 0 with traffic offered: everything must stay 0.
    idle();
    wbValid = 2'b11;
    #3;
    check("rst_ready", wbReady, 2'b00);
    check("rst_en_sc", regWrEnSc, 1'b0);
    check("rst_en_vec", regWrEnVec, 1'b0);
    check("rst_addr", regToWrite, 4'd0);
    check("rst_data", dataIn, '0);
    check("rst_err", resvErr, 1'b0);
    @(negedge clk);
    idle();
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check($sformatf("row%0d_ready", i), wbReady, tbl[i].rdy);
      check($sformatf("row%0d_en_sc", i), regWrEnSc, tbl[i].esc);
      check($sformatf("row%0d_en_vec", i), regWrEnVec, tbl[i].evec);
      check($sformatf("row%0d_addr", i), regToWrite, tbl[i].addr);
      check($sformatf("row%0d_data", i), dataIn, {16{tbl[i].dat}});
      check($sformatf("row%0d_hazard1", i), hazard1, tbl[i].h1);
      check($sformatf("row%0d_hazard2", i), hazard2, tbl[i].h2);
      check($sformatf("row%0d_err", i), resvErr, tbl[i].err);
    end

    // Reserve scalar 7 while ALU writes 7, then re-reserve on the retiring edge.
    @(negedge clk);
    idle();
    wbValid = 2'b01; wbReg0 = 4'd7; wbData0 = {16{8'h77}};
    resvEn = 1'b1; resvReg = 4'd7; qSel1 = 4'd7;
    #1;
    check("r7_ready", wbReady, 2'b01);
    check("r7_hazard_pre", hazard1, 1'b0);
    @(negedge clk);
    idle();
    resvEn = 1'b1; resvReg = 4'd7; qSel1 = 4'd7;
    #1;
    check("r7_wr_en", regWrEnSc, 1'b1);
    check("r7_wr_addr", regToWrite, 4'd7);
    check("r7_hazard_busy", hazard1, 1'b1);
    @(negedge clk);
    idle();
    qSel1 = 4'd7;
    #1;
    check("r7_set_wins", hazard1, 1'b1);
    check("r7_no_err", resvErr, 1'b0);
    check("r7_en_off", regWrEnSc, 1'b0);

    // Double reservation of scalar 4 is a WAW error that stays sticky.
    @(negedge clk);
    idle();
    resvEn = 1'b1; resvReg = 4'd4;
    @(negedge clk);
    idle();
    resvEn = 1'b1; resvReg = 4'd4; qSel2 = 4'd4;
    #1;
    check("r4_busy", hazard2, 1'b1);
    check("r4_err_before", resvErr, 1'b0);
    @(negedge clk);
    idle();
    qSel2 = 4'd4; wbValid = 2'b01; wbReg0 = 4'd4; wbData0 = {16{8'h44}};
    #1;
    check("r4_err_set", resvErr, 1'b1);
    check("r4_ready", wbReady, 2'b01);
    @(negedge clk);
    idle();
    qSel2 = 4'd4;
    #1;
    check("r4_wr_addr", regToWrite, 4'd4);
    check("r4_wr_data", dataIn, {16{8'h44}});
    check("r4_hazard_wstage", hazard2, 1'b1);
    @(negedge clk);
    idle();
    qSel2 = 4'd4;
    #1;
    check("r4_hazard_clear", hazard2, 1'b0);
    check("r4_err_sticky", resvErr, 1'b1);

    // Asynchronous reset in the middle of an active write stage.
    @(negedge clk);
    idle();
    wbValid = 2'b11; wbReg0 = 4'd2; wbReg1 = 4'd9; wbData1 = {16{8'h99}}; qSel1 = 4'd7;
    #1;
    check("arst_ready_tie", wbReady, 2'b10);
    @(negedge clk);
    #1;
    check("arst_wr_en", regWrEnSc, 1'b1);
    check("arst_wr_addr", regToWrite, 4'd9);
    check("arst_ready_next", wbReady, 2'b01);
    check("arst_busy7", hazard1, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_ready0", wbReady, 2'b00);
    check("arst_en0", regWrEnSc, 1'b0);
    check("arst_addr0", regToWrite, 4'd0);
    check("arst_data0", dataIn, '0);
    check("arst_err0", resvErr, 1'b0);
    check("arst_hazard0", hazard1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_ptr_src0", wbReady, 2'b01);
    check("arst_hazard_after", hazard1, 1'b0);

    @(negedge clk);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
